// File: rtl/mmio_timer_bank_if.sv
// AXI4-Lite slave bus bundle for the MMIO timer bank.
// The signal names follow the AXI channel names so an instance called S_AXI reads naturally.
interface mmio_timer_bank_if;
  logic [7:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/mmio_timer_bank.sv
// Bank of NUM_CH down-counting timers behind an AXI4-Lite register window.
// One channel per 16-byte slot: CTRL, RELOAD, COUNT (RO), STATUS (W1C).

module mmio_timer_ch #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             wr_ctrl_i,
  input  logic             wr_reload_i,
  input  logic             wr_status_i,
  input  logic [31:0]      wdata_i,
  input  logic [3:0]       wstrb_i,
  output logic [2:0]       ctrl_o,
  output logic [CNT_W-1:0] reload_o,
  output logic [CNT_W-1:0] count_o,
  output logic             expired_o
);
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} st_e;

  st_e              st_q, st_d;
  logic             ar_q, ar_d, ie_q, ie_d, exp_q, exp_d;
  logic [CNT_W-1:0] rl_q, rl_d, cnt_q, cnt_d, rl_wr;
  logic             en_wr;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i;

  always_comb begin
    rl_wr = rl_q;
    for (int b = 0; b < CNT_W; b++)
      if (wstrb_i[b/8]) rl_wr[b] = wdata_i[b];
  end

  always_comb begin
    st_d  = st_q;
    ar_d  = ar_q;
    ie_d  = ie_q;
    rl_d  = rl_q;
    cnt_d = cnt_q;
    exp_d = exp_q & ~(wr_status_i & wstrb_i[0] & wdata_i[0]);
    en_wr = (st_q == RUN);
    if (wr_ctrl_i && wstrb_i[0]) begin
      en_wr = wdata_i[0];
      ar_d  = wdata_i[1];
      ie_d  = wdata_i[2];
    end
    if (wr_reload_i) begin
      rl_d = rl_wr;
      if (st_q == IDLE) cnt_d = rl_wr;
    end
    // Expiry is applied after the W1C so a same-cycle set wins.
    if (st_q == IDLE && en_wr) begin
      st_d  = RUN;
      cnt_d = rl_q;
    end else if (st_q == RUN && !en_wr) begin
      st_d = IDLE;
    end else if (st_q == RUN && tick_i) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        exp_d = 1'b1;
        if (ar_d) cnt_d = rl_q;
        else      st_d  = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      ar_q  <= 1'b0;
      ie_q  <= 1'b0;
      exp_q <= 1'b0;
      rl_q  <= '0;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      ar_q  <= ar_d;
      ie_q  <= ie_d;
      exp_q <= exp_d;
      rl_q  <= rl_d;
      cnt_q <= cnt_d;
    end
  end

  assign ctrl_o    = {ie_q, ar_q, st_q == RUN};
  assign reload_o  = rl_q;
  assign count_o   = cnt_q;
  assign expired_o = exp_q;
endmodule

module mmio_timer_bank #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mmio_timer_bank_if.slave  S_AXI,
  output logic [NUM_CH-1:0] irq
);
  localparam logic [1:0] RESP_OK  = 2'b00;
  localparam logic [1:0] RESP_SLV = 2'b10;
  localparam logic [1:0] RESP_DEC = 2'b11;

  logic [15:0] psc_q, psc_d;
  logic        tick;

  logic        wacc_q, bvalid_q;
  logic [1:0]  bresp_q, bresp_d;
  logic        racc_q, rvalid_q;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wr_fire;
  logic        unused_prot;

  logic [NUM_CH-1:0]            wr_ctrl, wr_rl, wr_st, ch_exp;
  logic [NUM_CH-1:0][2:0]       ch_ctrl;
  logic [NUM_CH-1:0][CNT_W-1:0] ch_rl, ch_cnt;

  assign unused_prot = ^{S_AXI.awprot, S_AXI.arprot};

  function automatic logic [1:0] decode(input logic [7:0] a, input logic is_wr);
    if (a >= 8'(NUM_CH * 16)) return RESP_DEC;
    if (a[1:0] != 2'b00 || (is_wr && a[3:2] == 2'd2)) return RESP_SLV;
    return RESP_OK;
  endfunction

  assign tick  = (psc_q == 16'(PRESCALE - 1));
  assign psc_d = tick ? '0 : psc_q + 16'd1;

  // awready high means the handshake completes at the coming edge.
  assign wr_fire = wacc_q;
  assign bresp_d = decode(S_AXI.awaddr, 1'b1);

  always_comb begin
    wr_ctrl = '0;
    wr_rl   = '0;
    wr_st   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_fire && bresp_d == RESP_OK && S_AXI.awaddr[7:4] == 4'(c)) begin
        wr_ctrl[c] = (S_AXI.awaddr[3:2] == 2'd0);
        wr_rl[c]   = (S_AXI.awaddr[3:2] == 2'd1);
        wr_st[c]   = (S_AXI.awaddr[3:2] == 2'd3);
      end
    end
  end

  always_comb begin
    rresp_d = decode(S_AXI.araddr, 1'b0);
    rdata_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (rresp_d == RESP_OK && S_AXI.araddr[7:4] == 4'(c)) begin
        case (S_AXI.araddr[3:2])
          2'd0:    rdata_d = 32'(ch_ctrl[c]);
          2'd1:    rdata_d = 32'(ch_rl[c]);
          2'd2:    rdata_d = 32'(ch_cnt[c]);
          default: rdata_d = 32'(ch_exp[c]);
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q    <= '0;
      wacc_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= '0;
      racc_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rresp_q  <= '0;
      rdata_q  <= '0;
    end else begin
      psc_q  <= psc_d;
      wacc_q <= S_AXI.awvalid && S_AXI.wvalid && !bvalid_q && !wacc_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else if (bvalid_q && S_AXI.bready) begin
        bvalid_q <= 1'b0;
      end
      racc_q <= S_AXI.arvalid && !rvalid_q && !racc_q;
      if (racc_q) begin
        rvalid_q <= 1'b1;
        rresp_q  <= rresp_d;
        rdata_q  <= rdata_d;
      end else if (rvalid_q && S_AXI.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mmio_timer_ch #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .wr_ctrl_i   (wr_ctrl[c]),
      .wr_reload_i (wr_rl[c]),
      .wr_status_i (wr_st[c]),
      .wdata_i     (S_AXI.wdata),
      .wstrb_i     (S_AXI.wstrb),
      .ctrl_o      (ch_ctrl[c]),
      .reload_o    (ch_rl[c]),
      .count_o     (ch_cnt[c]),
      .expired_o   (ch_exp[c])
    );
    assign irq[c] = ch_exp[c] & ch_ctrl[c][2];
  end

  assign S_AXI.awready = wacc_q;
  assign S_AXI.wready  = wacc_q;
  assign S_AXI.bvalid  = bvalid_q;
  assign S_AXI.bresp   = bresp_q;
  assign S_AXI.arready = racc_q;
  assign S_AXI.rvalid  = rvalid_q;
  assign S_AXI.rresp   = rresp_q;
  assign S_AXI.rdata   = rdata_q;
endmodule

// File: tb/tb_mmio_timer_bank.sv
// Directed plus randomized bench for mmio_timer_bank; expected timer values are
// computed arithmetically from the enable edge number rather than stepped per cycle.
module tb_mmio_timer_bank;
  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NUM_CH-1:0] irq;
  always #5 clk = ~clk;

  mmio_timer_bank_if bus();
  mmio_timer_bank #(.NUM_CH(NUM_CH), .CNT_W(32), .PRESCALE(1)) dut (
    .clk(clk), .rst(rst), .S_AXI(bus.slave), .irq(irq));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;

  // Model: a running channel is described by its enable edge, reload and mode.
  bit          m_run [NUM_CH];
  bit          m_auto[NUM_CH];
  bit          m_ie  [NUM_CH];
  bit          m_xs  [NUM_CH];
  int          m_e   [NUM_CH];
  int unsigned m_R   [NUM_CH];
  int unsigned m_idle[NUM_CH];

  function automatic int unsigned mc_count(int c, int n);
    int k;
    if (!m_run[c]) return m_idle[c];
    k = n - m_e[c];
    if (m_auto[c]) return m_R[c] - (k % (m_R[c] + 1));
    return (k <= m_R[c]) ? m_R[c] - k : 0;
  endfunction

  function automatic bit mc_en(int c, int n);
    return m_run[c] && (m_auto[c] || (n - m_e[c]) <= m_R[c]);
  endfunction

  function automatic bit mc_exp(int c, int n);
    return m_xs[c] || (m_run[c] && (n - m_e[c]) >= m_R[c] + 1);
  endfunction

  function automatic logic [31:0] mc_ctrl(int c, int n);
    return {29'd0, m_ie[c], m_auto[c], mc_en(c, n)};
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_run[c] = 0; m_auto[c] = 0; m_ie[c] = 0; m_xs[c] = 0;
      m_e[c] = 0; m_R[c] = 0; m_idle[c] = 0;
    end
  endtask

  // Freeze a channel whose one-shot has ended (or is being stopped at edge n+1).
  task automatic m_freeze(int c, int n);
    if (m_run[c]) begin
      m_idle[c] = mc_count(c, n);
      m_xs[c]   = mc_exp(c, n);
      m_run[c]  = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_irq(input string tag);
    logic [NUM_CH-1:0] e;
    for (int c = 0; c < NUM_CH; c++) e[c] = mc_exp(c, cyc) && m_ie[c];
    chk(tag, 32'(irq), 32'(e));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic [1:0] resp, output int ue);
    bit ok = 0;
    ue = -1;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.awready === 1'b1) begin ok = 1; ue = cyc + 1; end
    end
    chk("aw_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.bvalid === 1'b1) ok = 1;
    end
    chk("b_valid", 32'(ok), 32'd1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp,
                    output int cap);
    bit ok = 0;
    cap = -1;
    bus.araddr = a; bus.arvalid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.arready === 1'b1) begin ok = 1; cap = cyc + 1; end
    end
    chk("ar_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.rvalid === 1'b1) ok = 1;
    end
    chk("r_valid", 32'(ok), 32'd1);
    d = bus.rdata; resp = bus.rresp;
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d, first, expv;
    int          ue, cap, c, r, wait_n;
    logic [2:0]  mode;
    bit          ok, seen;

    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 0; bus.wdata = '0; bus.wstrb = '0;
    bus.wvalid = 0; bus.bready = 0; bus.araddr = '0; bus.arprot = '0; bus.arvalid = 0;
    bus.rready = 0;
    m_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 0);
    chk("rst_arready", 32'(bus.arready), 0);
    chk("rst_bvalid",  32'(bus.bvalid), 0);
    chk("rst_rvalid",  32'(bus.rvalid), 0);
    chk("rst_bresp",   32'(bus.bresp), 0);
    chk("rst_rresp",   32'(bus.rresp), 0);
    chk("rst_rdata",   bus.rdata, 0);
    chk("rst_irq",     32'(irq), 0);
    rst = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      rd(8'(i * 16), d, resp, cap);      chk("rst_ctrl", d, 0);
      rd(8'(i * 16 + 8), d, resp, cap);  chk("rst_count", d, 0);
    end

    // Auto-reload channel 0 from 200.
    wr(8'h04, 200, 4'hF, resp, ue); chk("reload_resp", 32'(resp), 0);
    m_R[0] = 200; m_idle[0] = 200;
    wr(8'h00, 3, 4'hF, resp, ue);   chk("ctrl_resp", 32'(resp), 0);
    m_run[0] = 1; m_e[0] = ue; m_auto[0] = 1; m_ie[0] = 0;
    rd(8'h08, d, resp, cap); chk("count_a", d, mc_count(0, cap - 1)); first = d;
    rd(8'h08, d, resp, cap); chk("count_b", d, mc_count(0, cap - 1));
    chk("count_decreasing", 32'(d < first), 1);
    while (cyc < m_e[0] + 205) @(negedge clk);
    rd(8'h0C, d, resp, cap); chk("auto_expired", d, 32'(mc_exp(0, cap - 1)));
    chk("auto_expired_set", d, 1);
    rd(8'h08, d, resp, cap); chk("auto_count", d, mc_count(0, cap - 1));
    rd(8'h00, d, resp, cap); chk("auto_ctrl", d, mc_ctrl(0, cap - 1));
    wr(8'h00, 0, 4'hF, resp, ue); m_freeze(0, ue - 1); m_auto[0] = 0;
    wr(8'h0C, 1, 4'hF, resp, ue); m_xs[0] = 0;
    rd(8'h0C, d, resp, cap); chk("w1c_status", d, 0);

    // One-shot channel 0 with interrupt.
    wr(8'h04, 5, 4'hF, resp, ue); m_R[0] = 5; m_idle[0] = 5;
    wr(8'h00, 5, 4'hF, resp, ue);
    m_run[0] = 1; m_e[0] = ue; m_auto[0] = 0; m_ie[0] = 1;
    while (cyc < m_e[0] + 6) @(negedge clk);
    chk_irq("oneshot_irq_model");
    chk("oneshot_irq0", 32'(irq[0]), 1);
    rd(8'h00, d, resp, cap); chk("oneshot_ctrl", d, mc_ctrl(0, cap - 1));
    rd(8'h08, d, resp, cap); chk("oneshot_count", d, 0);
    wr(8'h0C, 1, 4'hF, resp, ue); m_freeze(0, ue - 1); m_xs[0] = 0;
    @(negedge clk); chk("oneshot_irq_clear", 32'(irq[0]), 0);
    wr(8'h00, 0, 4'hF, resp, ue); m_ie[0] = 0;

    // Decode errors.
    wr(8'h40, 32'h1234, 4'hF, resp, ue); chk("decerr_wr", 32'(resp), 3);
    rd(8'h40, d, resp, cap); chk("decerr_rresp", 32'(resp), 3); chk("decerr_rdata", d, 0);
    wr(8'h08, 32'h55, 4'hF, resp, ue); chk("count_wr_slverr", 32'(resp), 2);
    rd(8'h08, d, resp, cap); chk("count_unchanged", d, mc_count(0, cap - 1));
    rd(8'h06, d, resp, cap); chk("misaligned_rd", 32'(resp), 2);
    wr(8'h05, 32'hFF, 4'hF, resp, ue); chk("misaligned_wr", 32'(resp), 2);

    // Byte lanes on channel 1 RELOAD, then a strobe-less CTRL write.
    wr(8'h14, 32'hAABBCCDD, 4'b0101, resp, ue);
    expv = m_R[1];
    for (int b = 0; b < 4; b++) if (b % 2 == 0) expv[b*8 +: 8] = 8'(32'hAABBCCDD >> (b * 8));
    m_R[1] = expv; m_idle[1] = expv;
    rd(8'h14, d, resp, cap); chk("strobe_reload", d, m_R[1]);
    rd(8'h18, d, resp, cap); chk("strobe_count", d, mc_count(1, cap - 1));
    wr(8'h10, 32'h7, 4'b0000, resp, ue);
    rd(8'h10, d, resp, cap); chk("nostrobe_ctrl", d, mc_ctrl(1, cap - 1));

    // Back-pressure: second write must wait for the first response.
    bus.awaddr = 8'h14; bus.wdata = 7; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (bus.awready === 1'b1); end
    chk("bp_first_accept", 32'(ok), 1);
    @(posedge clk); #1;
    bus.wdata = 9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_awready_low", 32'(bus.awready), 0);
      chk("bp_bvalid_held", 32'(bus.bvalid), 1);
    end
    bus.bready = 1; @(posedge clk); #1; bus.bready = 0;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (bus.awready === 1'b1); end
    chk("bp_second_accept", 32'(ok), 1);
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk); chk("bp_second_bvalid", 32'(bus.bvalid), 1);
    chk("bp_second_bresp", 32'(bus.bresp), 0);
    bus.bready = 1; @(posedge clk); #1; bus.bready = 0;
    m_R[1] = 9; m_idle[1] = 9;
    rd(8'h18, d, resp, cap); chk("bp_count", d, mc_count(1, cap - 1));

    // Randomized trials.
    for (int t = 0; t < 8; t++) begin
      c = $urandom_range(0, NUM_CH - 1);
      r = $urandom_range(2, 30);
      mode = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      wr(8'(c * 16 + 4), 32'(r), 4'hF, resp, ue); m_R[c] = r; m_idle[c] = r;
      wr(8'(c * 16), 32'(mode), 4'hF, resp, ue);
      m_run[c] = 1; m_e[c] = ue; m_auto[c] = mode[1]; m_ie[c] = mode[2];
      wait_n = $urandom_range(0, 70);
      repeat (wait_n) @(negedge clk);
      chk_irq("rnd_irq");
      rd(8'(c * 16 + 8), d, resp, cap); chk("rnd_count", d, mc_count(c, cap - 1));
      rd(8'(c * 16 + 12), d, resp, cap); chk("rnd_status", d, 32'(mc_exp(c, cap - 1)));
      rd(8'(c * 16), d, resp, cap); chk("rnd_ctrl", d, mc_ctrl(c, cap - 1));
      wr(8'(c * 16), 0, 4'hF, resp, ue); m_freeze(c, ue - 1); m_auto[c] = 0; m_ie[c] = 0;
      wr(8'(c * 16 + 12), 1, 4'hF, resp, ue); m_xs[c] = 0;
      rd(8'(c * 16 + 12), d, resp, cap); chk("rnd_cleared", d, 0);
    end

    // Reset while a write response is pending and channel 2 runs.
    wr(8'h24, 100, 4'hF, resp, ue); m_R[2] = 100; m_idle[2] = 100;
    wr(8'h20, 7, 4'hF, resp, ue); m_run[2] = 1; m_e[2] = ue; m_auto[2] = 1; m_ie[2] = 1;
    bus.awaddr = 8'h24; bus.wdata = 50; bus.wstrb = 4'hF; bus.awvalid = 1; bus.wvalid = 1;
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin @(negedge clk); ok = (bus.awready === 1'b1); end
    chk("abort_accept", 32'(ok), 1);
    @(posedge clk); #1;
    bus.awvalid = 0; bus.wvalid = 0;
    @(negedge clk); chk("abort_bvalid_pending", 32'(bus.bvalid), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bvalid_cleared", 32'(bus.bvalid), 0);
    chk("abort_irq", 32'(irq), 0);
    rst = 1'b0;
    m_reset();
    seen = 0;
    repeat (4) begin @(negedge clk); if (bus.bvalid !== 1'b0) seen = 1; end
    chk("abort_no_late_resp", 32'(seen), 0);
    for (int i = 0; i < NUM_CH; i++) begin
      rd(8'(i * 16), d, resp, cap);     chk("post_rst_ctrl", d, mc_ctrl(i, cap - 1));
      rd(8'(i * 16 + 8), d, resp, cap); chk("post_rst_count", d, mc_count(i, cap - 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
